// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared opcodes, halt word and fetch state encoding
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;

  // Reserved all-ones word that stops the fetch sequencer.
  localparam logic [31:0] HALT_INSTR = 32'hFFFF_FFFF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DECODE,
    ST_UPDATE,
    ST_HALT
  } fetch_state_e;

endpackage

// File: rtl/instr_mem.sv
// rtl/instr_mem.sv - single-port synchronous instruction RAM
// Purpose: DEPTH x 32 RAM, one shared address port. Writes and reads are
// both registered; the read register is the fetched instruction word.
// Ports:
//   clk_i    clock
//   rst_i    synchronous active-high reset of the read register only
//   we_i     write strobe (mem[addr_i] <= wdata_i)
//   re_i     read strobe  (rdata_o <= mem[addr_i])
//   addr_i   word address
//   wdata_i  write data
//   rdata_o  registered read data; holds when re_i is low
module instr_mem #(
  parameter int DEPTH = 256,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          we_i,
  input  logic          re_i,
  input  logic [AW-1:0] addr_i,
  input  logic [31:0]   wdata_i,
  output logic [31:0]   rdata_o
);

  logic [31:0] mem_q [DEPTH];
  logic [31:0] rdata_q;

  // Array contents are deliberately not reset.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= mem_q[addr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/instruction_fetch.sv
// rtl/instruction_fetch.sv - PC, instruction memory and fetch sequencer
// Purpose: steps each instruction through FETCH, DECODE and UPDATE so the
// registered control unit sees a stable word before the PC advances.
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   en                   run enable, sampled in IDLE and UPDATE
//   jump, branch, zero   next-PC selects, used only in UPDATE
//   imem_we/waddr/wdata  program load port, honoured only in IDLE
//   instr, opcode        current instruction word and its [31:26] field
//   pc, pc_plus4         current instruction address and pc + 4
//   instr_valid          high in DECODE and UPDATE
//   halt                 high once the sequencer has stopped
module instruction_fetch
  import mips_pkg::*;
#(
  parameter int                    IMEM_DEPTH = 256,
  parameter int                    PC_WIDTH   = 32,
  parameter logic [PC_WIDTH-1:0]   RESET_PC   = '0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          en,
  input  logic                          jump,
  input  logic                          branch,
  input  logic                          zero,
  input  logic                          imem_we,
  input  logic [$clog2(IMEM_DEPTH)-1:0] imem_waddr,
  input  logic [31:0]                   imem_wdata,
  output logic [31:0]                   instr,
  output logic [5:0]                    opcode,
  output logic [PC_WIDTH-1:0]           pc,
  output logic [PC_WIDTH-1:0]           pc_plus4,
  output logic                          instr_valid,
  output logic                          halt
);

  localparam int AW = $clog2(IMEM_DEPTH);
  localparam logic [PC_WIDTH-3:0] DEPTH_WORDS = (PC_WIDTH-2)'(IMEM_DEPTH);

  fetch_state_e        state_q, state_d;
  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic [PC_WIDTH-1:0] pc_plus4_w;
  logic [PC_WIDTH-1:0] next_pc;
  logic [PC_WIDTH-1:0] branch_off;
  logic [31:0]         instr_w;
  logic                pc_in_range;
  logic                mem_we;
  logic                mem_re;
  logic [AW-1:0]       mem_addr;

  // The RAM read register doubles as the instruction register, so a
  // FETCH that is suppressed (out of range) leaves instr untouched.
  instr_mem #(
    .DEPTH (IMEM_DEPTH),
    .AW    (AW)
  ) u_instr_mem (
    .clk_i   (clk),
    .rst_i   (rst),
    .we_i    (mem_we),
    .re_i    (mem_re),
    .addr_i  (mem_addr),
    .wdata_i (imem_wdata),
    .rdata_o (instr_w)
  );

  assign pc_plus4_w  = pc_q + PC_WIDTH'(4);
  assign pc_in_range = pc_q[PC_WIDTH-1:2] < DEPTH_WORDS;
  assign branch_off  = {{(PC_WIDTH-18){instr_w[15]}}, instr_w[15:0], 2'b00};

  always_comb begin
    next_pc = pc_plus4_w;
    if (jump) begin
      next_pc = {pc_plus4_w[PC_WIDTH-1:28], instr_w[25:0], 2'b00};
    end else if (branch && zero) begin
      next_pc = pc_plus4_w + branch_off;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    mem_we   = 1'b0;
    mem_re   = 1'b0;
    mem_addr = pc_q[AW+1:2];
    case (state_q)
      ST_IDLE: begin
        // Load port owns the RAM address only while idle.
        mem_we   = imem_we;
        mem_addr = imem_waddr;
        if (en) begin
          state_d = ST_FETCH;
        end
      end
      ST_FETCH: begin
        if (pc_in_range) begin
          mem_re  = 1'b1;
          state_d = ST_DECODE;
        end else begin
          state_d = ST_HALT;
        end
      end
      ST_DECODE: begin
        state_d = ST_UPDATE;
      end
      ST_UPDATE: begin
        if (instr_w == HALT_INSTR) begin
          state_d = ST_HALT;
        end else begin
          pc_d    = next_pc;
          state_d = en ? ST_FETCH : ST_IDLE;
        end
      end
      ST_HALT: begin
        state_d = ST_HALT;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign instr       = instr_w;
  assign opcode      = instr_w[31:26];
  assign pc          = pc_q;
  assign pc_plus4    = pc_plus4_w;
  assign instr_valid = (state_q == ST_DECODE) || (state_q == ST_UPDATE);
  assign halt        = (state_q == ST_HALT);

endmodule

// File: tb/tb_instruction_fetch.sv
// tb/tb_instruction_fetch.sv - directed self-checking bench for instruction_fetch
module tb_instruction_fetch;

  localparam logic [31:0] NOP    = 32'h0000_0020;
  localparam logic [31:0] ADD0   = 32'h012A_4020;
  localparam logic [31:0] ADD1   = 32'h016C_4820;
  localparam logic [31:0] HALTW  = 32'hFFFF_FFFF;
  localparam logic [31:0] J_40   = 32'h0800_0040;
  localparam logic [31:0] J_08   = 32'h0800_0008;
  localparam logic [31:0] J_04   = 32'h0800_0004;
  localparam logic [31:0] BEQ_M4 = 32'h1000_FFFC;
  localparam logic [31:0] BEQ_FW = 32'h1000_00F4;
  localparam logic [31:0] JUNK   = 32'hDEAD_BEEF;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        en = 1'b0;
  logic        jump = 1'b0;
  logic        branch = 1'b0;
  logic        zero = 1'b0;
  logic        imem_we = 1'b0;
  logic [7:0]  imem_waddr = '0;
  logic [31:0] imem_wdata = '0;
  logic [31:0] instr;
  logic [5:0]  opcode;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        instr_valid;
  logic        halt;

  int checks = 0;
  int errors = 0;

  instruction_fetch #(
    .IMEM_DEPTH (256),
    .PC_WIDTH   (32),
    .RESET_PC   (32'h0000_0000)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .jump        (jump),
    .branch      (branch),
    .zero        (zero),
    .imem_we     (imem_we),
    .imem_waddr  (imem_waddr),
    .imem_wdata  (imem_wdata),
    .instr       (instr),
    .opcode      (opcode),
    .pc          (pc),
    .pc_plus4    (pc_plus4),
    .instr_valid (instr_valid),
    .halt        (halt)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    imem_we    = 1'b1;
    imem_waddr = a;
    imem_wdata = d;
    step();
    imem_we    = 1'b0;
  endtask

  // Starts in FETCH, ends after the UPDATE edge.
  task automatic run_instr(input logic j, input logic b, input logic z);
    jump = j; branch = b; zero = z;
    repeat (3) step();
    jump = 1'b0; branch = 1'b0; zero = 1'b0;
  endtask

  initial begin
    // Reset values
    rst = 1'b1; step(); rst = 1'b0;
    check("rst_pc", pc, 32'h0);
    check("rst_instr", instr, 32'h0);
    check("rst_opcode", {26'h0, opcode}, 32'h0);
    check("rst_valid", {31'h0, instr_valid}, 32'h0);
    check("rst_halt", {31'h0, halt}, 32'h0);
    check("rst_pc4", pc_plus4, 32'h4);

    // Straight-line program ending in HALT
    wr(8'd0, ADD0); wr(8'd1, ADD1); wr(8'd2, HALTW);
    en = 1'b1;
    step();
    check("p1_fetch_pc", pc, 32'h0);
    check("p1_fetch_valid", {31'h0, instr_valid}, 32'h0);
    step();
    check("p1_dec_instr", instr, ADD0);
    check("p1_dec_valid", {31'h0, instr_valid}, 32'h1);
    step();
    check("p1_upd_valid", {31'h0, instr_valid}, 32'h1);
    check("p1_upd_pc", pc, 32'h0);
    step();
    check("p1_pc4", pc, 32'h4);
    check("p1_next_valid", {31'h0, instr_valid}, 32'h0);
    repeat (3) step();
    check("p1_pc8", pc, 32'h8);
    step(); step();
    check("p1_halt_word", instr, HALTW);
    step();
    check("p1_halt", {31'h0, halt}, 32'h1);
    check("p1_halt_pc", pc, 32'h8);
    check("p1_halt_valid", {31'h0, instr_valid}, 32'h0);
    repeat (4) step();
    check("p1_halt_hold_pc", pc, 32'h8);
    check("p1_halt_sticky", {31'h0, halt}, 32'h1);

    // Control-flow program
    en = 1'b0;
    rst = 1'b1; step(); rst = 1'b0;
    check("p2_rst_halt", {31'h0, halt}, 32'h0);
    for (int i = 0; i < 4; i++) wr(8'(i), NOP);
    wr(8'd4, J_40);
    for (int i = 5; i < 8; i++) wr(8'(i), NOP);
    wr(8'd8, BEQ_M4);
    wr(8'd9, NOP); wr(8'd10, NOP);
    wr(8'd11, BEQ_FW);
    wr(8'd64, J_08);
    en = 1'b1;
    step();
    for (int i = 0; i < 4; i++) run_instr(1'b0, 1'b0, 1'b0);
    check("p2_pc10", pc, 32'h10);
    run_instr(1'b1, 1'b1, 1'b1);
    check("p2_jump_prio", pc, 32'h100);
    run_instr(1'b1, 1'b0, 1'b0);
    check("p2_jump_back", pc, 32'h20);
    step();
    check("p2_beq_opcode", {26'h0, opcode}, 32'h4);
    jump = 1'b0; branch = 1'b1; zero = 1'b1;
    step(); step();
    branch = 1'b0; zero = 1'b0;
    check("p2_beq_taken", pc, 32'h14);
    for (int i = 0; i < 3; i++) run_instr(1'b0, 1'b0, 1'b0);
    check("p2_pc20_again", pc, 32'h20);
    run_instr(1'b0, 1'b1, 1'b0);
    check("p2_beq_not_taken", pc, 32'h24);

    // en drop and blocked write during FETCH (state is FETCH at pc 0x24)
    imem_we = 1'b1; imem_waddr = 8'd10; imem_wdata = JUNK;
    step();
    imem_we = 1'b0; en = 1'b0;
    step(); step();
    check("p3_idle_pc", pc, 32'h28);
    check("p3_idle_valid", {31'h0, instr_valid}, 32'h0);
    step(); step();
    check("p3_idle_hold", pc, 32'h28);
    en = 1'b1;
    step(); step();
    check("p3_resume_instr", instr, NOP);
    check("p3_resume_pc", pc, 32'h28);
    step(); step();
    check("p3_resume_next", pc, 32'h2C);

    // Branch past end of memory
    run_instr(1'b0, 1'b1, 1'b1);
    check("p4_pc_oob", pc, 32'h400);
    step();
    check("p4_oob_halt", {31'h0, halt}, 32'h1);
    check("p4_oob_instr", instr, BEQ_FW);
    check("p4_oob_pc", pc, 32'h400);

    // Reset during UPDATE of a jump; write and en on the same edge
    en = 1'b0;
    rst = 1'b1; step(); rst = 1'b0;
    en = 1'b1;
    wr(8'd0, J_04);
    step();
    check("p5_newdata", instr, J_04);
    check("p5_opcode", {26'h0, opcode}, 32'h2);
    jump = 1'b1;
    step();
    check("p5_in_update", {31'h0, instr_valid}, 32'h1);
    rst = 1'b1; en = 1'b0;
    step();
    rst = 1'b0; jump = 1'b0;
    check("p5_rst_pc", pc, 32'h0);
    check("p5_rst_instr", instr, 32'h0);
    check("p5_rst_valid", {31'h0, instr_valid}, 32'h0);
    check("p5_rst_halt", {31'h0, halt}, 32'h0);
    step(); step();
    check("p5_no_target", pc, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
